// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
interface nibble_serial_adder_if;
   logic       start;
   logic       c_in;
   logic       abort;
   logic [3:0] a_nib;
   logic [3:0] b_nib;
   logic       in_valid;
   logic       in_ready;
   logic       busy;
   logic [3:0] sum_nib;
   logic       sum_valid;
   logic       c_out;
   logic       overflow;
   logic       done;

   modport master (
      output start, c_in, abort, a_nib, b_nib, in_valid,
      input  in_ready, busy, sum_nib, sum_valid, c_out, overflow, done
   );

   modport slave (
      input  start, c_in, abort, a_nib, b_nib, in_valid,
      output in_ready, busy, sum_nib, sum_valid, c_out, overflow, done
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WORDS-nibble serial adder, LS nibble first, chained carry
module nibble_serial_adder #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cy_q, cy_d;
   logic [3:0]      sum_nib_q, sum_nib_d;
   logic            sum_valid_q, sum_valid_d;
   logic            c_out_q, c_out_d;
   logic            overflow_q, overflow_d;
   logic            done_q, done_d;

   logic [4:0]      add_w;
   logic            ovf_w;

   assign add_w = {1'b0, bus.a_nib} + {1'b0, bus.b_nib} + {4'b0000, cy_q};
   // Signed overflow is judged on the top nibble only, so it is meaningful on the last beat.
   assign ovf_w = (bus.a_nib[3] == bus.b_nib[3]) && (add_w[3] != bus.a_nib[3]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cy_q        <= 1'b0;
         sum_nib_q   <= 4'h0;
         sum_valid_q <= 1'b0;
         c_out_q     <= 1'b0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cy_q        <= cy_d;
         sum_nib_q   <= sum_nib_d;
         sum_valid_q <= sum_valid_d;
         c_out_q     <= c_out_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cy_d        = cy_q;
      sum_nib_d   = sum_nib_q;
      sum_valid_d = 1'b0;
      c_out_d     = c_out_q;
      overflow_d  = overflow_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cy_d       = bus.c_in;
               cnt_d      = '0;
               c_out_d    = 1'b0;
               overflow_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               cy_d    = 1'b0;
            end else if (bus.in_valid) begin
               sum_nib_d   = add_w[3:0];
               sum_valid_d = 1'b1;
               cy_d        = add_w[4];
               if (cnt_q == LAST) begin
                  c_out_d    = add_w[4];
                  overflow_d = ovf_w;
                  done_d     = 1'b1;
                  cnt_d      = '0;
                  state_d    = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs come straight from the state register, never from in_valid.
   assign bus.in_ready  = (state_q == RUN);
   assign bus.busy      = (state_q == RUN);
   assign bus.sum_nib   = sum_nib_q;
   assign bus.sum_valid = sum_valid_q;
   assign bus.c_out     = c_out_q;
   assign bus.overflow  = overflow_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - vector table, random and corner-case bench for nibble_serial_adder
module tb_nibble_serial_adder;

   logic clk;
   logic rst;

   nibble_serial_adder_if if0 ();
   nibble_serial_adder_if if1 ();

   nibble_serial_adder #(.WORDS(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
   nibble_serial_adder #(.WORDS(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sq[$];
   int         done_cnt;
   logic       done_c, done_v;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      int          gap;
      logic [15:0] s;
      logic        c;
      logic        v;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 output logic [15:0] s, output logic c, output logic v);
      logic [16:0] t;
      t = {1'b0, a} + {1'b0, b} + 17'(cin);
      s = t[15:0];
      c = t[16];
      v = (a[15] == b[15]) && (s[15] != a[15]);
   endfunction

   always @(negedge clk) begin
      if (if0.sum_valid) sq.push_back(if0.sum_nib);
      if (if0.done) begin
         done_cnt = done_cnt + 1;
         done_c   = if0.c_out;
         done_v   = if0.overflow;
      end
   end

   task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int gap, input string tag);
      sq.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      chk({tag, "_idle_ready"}, 32'(if0.in_ready), 32'd0);
      if0.start    = 1'b1;
      if0.c_in     = cin;
      if0.in_valid = 1'b1;
      if0.a_nib    = 4'hA;
      if0.b_nib    = 4'h5;
      @(posedge clk); #1;
      if0.start    = 1'b0;
      if0.in_valid = 1'b0;
      chk({tag, "_ready_after_start"}, 32'(if0.in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         int g;
         g = (gap == 0) ? 0 : int'($urandom_range(0, gap));
         repeat (g) begin
            if0.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         if0.in_valid = 1'b1;
         if0.a_nib    = a[4*i +: 4];
         if0.b_nib    = b[4*i +: 4];
         if0.start    = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if0.in_valid = 1'b0;
         if0.start    = 1'b0;
      end
      chk({tag, "_done_pulse"}, {29'd0, if0.done, if0.in_ready, if0.busy}, 32'b100);
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, 32'(if0.done), 32'd0);
   endtask

   task automatic check_result(input logic [15:0] s, input logic c, input logic v, input string tag);
      logic [15:0] got;
      got = 16'h0;
      chk({tag, "_pulses"}, 32'(sq.size()), 32'd4);
      for (int i = 0; i < 4 && i < sq.size(); i++) got[4*i +: 4] = sq[i];
      chk({tag, "_sum"}, 32'(got), 32'(s));
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_c_v"}, {30'd0, done_c, done_v}, {30'd0, c, v});
      chk({tag, "_c_v_hold"}, {30'd0, if0.c_out, if0.overflow}, {30'd0, c, v});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra, rb, es;
      logic        rc, ec, ev;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'h1234, 16'h4321, 1'b0, 5, 16'h5555, 1'b0, 1'b0};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 2, 16'hFFFF, 1'b1, 1'b0};

      rst = 1'b1;
      if0.start = 0; if0.c_in = 0; if0.abort = 0; if0.a_nib = 0; if0.b_nib = 0; if0.in_valid = 0;
      if1.start = 0; if1.c_in = 0; if1.abort = 0; if1.a_nib = 0; if1.b_nib = 0; if1.in_valid = 0;
      done_cnt = 0; done_c = 0; done_v = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {23'd0, if0.sum_nib, if0.sum_valid, if0.c_out, if0.overflow, if0.done, if0.in_ready, if0.busy},
          32'd0);
      rst = 1'b0;

      // abort while idle must not wake the block
      @(posedge clk); #1;
      if0.abort = 1'b1;
      @(posedge clk); #1;
      if0.abort = 1'b0;
      chk("idle_abort_busy", 32'(if0.busy), 32'd0);

      for (int i = 0; i < 6; i++) begin
         do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].gap, $sformatf("vec%0d", i));
         check_result(vecs[i].s, vecs[i].c, vecs[i].v, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         if (i % 6 == 0) ra = 16'h7FFF;
         if (i % 6 == 1) rb = 16'h8000;
         model(ra, rb, rc, es, ec, ev);
         do_add(ra, rb, rc, int'($urandom_range(0, 5)), $sformatf("rnd%0d", i));
         check_result(es, ec, ev, $sformatf("rnd%0d", i));
      end

      // abort on the third offered beat
      sq.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      if0.start = 1'b1; if0.c_in = 1'b0;
      @(posedge clk); #1;
      if0.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if0.in_valid = 1'b1; if0.a_nib = 4'h3; if0.b_nib = 4'h4;
         if (i == 2) if0.abort = 1'b1;
         @(posedge clk); #1;
         if0.in_valid = 1'b0; if0.abort = 1'b0;
      end
      chk("abort_idle", {30'd0, if0.busy, if0.in_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_pulses", 32'(sq.size()), 32'd2);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_c_v", {30'd0, if0.c_out, if0.overflow}, 32'd0);
      do_add(16'h0001, 16'h0001, 1'b0, 0, "post_abort");
      check_result(16'h0002, 1'b0, 1'b0, "post_abort");

      // asynchronous reset after two beats
      done_cnt = 0;
      @(posedge clk); #1;
      if0.start = 1'b1; if0.c_in = 1'b0;
      @(posedge clk); #1;
      if0.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if0.in_valid = 1'b1; if0.a_nib = 4'h1; if0.b_nib = 4'h4;
         @(posedge clk); #1;
      end
      if0.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs",
          {23'd0, if0.sum_nib, if0.sum_valid, if0.c_out, if0.overflow, if0.done, if0.in_ready, if0.busy},
          32'd0);
      #2;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
      chk("rst_mid_idle", 32'(if0.busy), 32'd0);

      // single-nibble instance: latency and back-to-back start in the done cycle
      @(posedge clk); #1;
      if1.start = 1'b1; if1.c_in = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      chk("w1_busy", 32'(if1.busy), 32'd1);
      if1.in_valid = 1'b1; if1.a_nib = 4'hF; if1.b_nib = 4'h0;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      chk("w1_first",
          {25'd0, if1.done, if1.sum_valid, if1.sum_nib, if1.c_out, if1.overflow, if1.busy},
          {25'd0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0});
      if1.start = 1'b1; if1.c_in = 1'b0;
      @(posedge clk); #1;
      if1.start = 1'b0;
      chk("w1_restart",
          {29'd0, if1.busy, if1.done, if1.c_out}, {29'd0, 1'b1, 1'b0, 1'b0});
      if1.in_valid = 1'b1; if1.a_nib = 4'h7; if1.b_nib = 4'h1;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      chk("w1_second",
          {25'd0, if1.done, if1.sum_valid, if1.sum_nib, if1.c_out, if1.overflow, if1.busy},
          {25'd0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      chk("w1_hold",
          {25'd0, if1.done, if1.sum_valid, if1.sum_nib, if1.c_out, if1.overflow, if1.busy},
          {25'd0, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential controller that performs a WORDS×4-bit addition by streaming operands one nibble per accepted beat, least-significant nibble first, through a 4-bit ripple add stage. The carry-out of each beat is registered and chained as the carry-in of the next beat. The block sits between the operand source and the result sink in the lab datapath. It lets the 4-bit adder build wide adds without widening the adder itself.

## Interface
- WORDS, 4, nibbles per operand (legal 1..16); total operand width = 4·WORDS
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new addition; honoured only in IDLE
- c_in  input  1  initial carry; sampled on the cycle start is honoured
- abort  input  1  synchronous cancel of an addition in progress
- a_nib  input  4  operand A nibble for the current beat
- b_nib  input  4  operand B nibble for the current beat
- in_valid  input  1  a_nib/b_nib are valid
- in_ready  output  1  block accepts a nibble this cycle; high exactly when state = RUN
- busy  output  1  high exactly when state = RUN
- sum_nib  output  4  registered sum nibble
- sum_valid  output  1  one-cycle pulse; sum_nib is valid
- c_out  output  1  final carry-out of the whole addition
- overflow  output  1  two's-complement overflow of the whole addition
- done  output  1  one-cycle pulse; addition complete, c_out/overflow valid

## Operation
- States: IDLE, RUN. Beat counter cnt has width max(1, ceil(log2(WORDS))). Carry register cy is 1 bit.
- IDLE, start=1:
  - cy ← c_in, cnt ← 0, c_out ← 0, overflow ← 0.
  - Next state RUN.
- RUN: accept occurs when in_valid && in_ready && !abort. On accept:
  - {c, s} = a_nib + b_nib + cy, computed as a 5-bit result.
  - sum_nib ← s, sum_valid ← 1, cy ← c.
  - If cnt < WORDS−1: cnt ← cnt+1 and stay in RUN.
  - If cnt = WORDS−1: c_out ← c, overflow ← (a_nib[3] == b_nib[3]) && (s[3] != a_nib[3]), done ← 1, next state IDLE.
- RUN, in_valid=0: a stall. No state change and sum_valid = 0. Stalls may be arbitrarily long.
- RUN, abort=1:
  - Next state IDLE; cnt and cy are cleared.
  - No sum_valid or done pulse occurs. c_out and overflow stay 0.
  - abort wins over a simultaneous in_valid; that nibble is not accepted.
- abort in IDLE: no effect. start in RUN: ignored.
- start and in_valid together in IDLE: the nibble is not accepted, because in_ready = 0.
- c_out and overflow hold their values after done until the next honoured start clears them.
- sum_nib holds its last value between pulses.
- Arithmetic is unsigned modulo 2^(4·WORDS). Overflow treats both operands as signed 4·WORDS-bit values.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, cnt = 0, cy = 0.
  - sum_nib = 0, sum_valid = 0, c_out = 0, overflow = 0, done = 0, in_ready = 0, busy = 0.
- Reset mid-addition discards everything. No done is produced.
- start is honoured at edge T. in_ready goes high in cycle T+1.
- A nibble accepted at edge E produces sum_nib/sum_valid in cycle E+1, giving 1-cycle latency.
- The last accept at edge E gives:
  - done, sum_valid, c_out and overflow valid in cycle E+1.
  - in_ready and busy low in cycle E+1.
- A new start may be asserted in the same cycle as done. It is honoured at that edge, so back-to-back additions are possible.
- Minimum addition time is WORDS+1 cycles from start to done. Throughput is one nibble per cycle with no stalls.
- in_ready and busy are decoded directly from the state register. They have no combinational path from in_valid.

## Test plan
- WORDS=4, start with c_in=0, stream 0x1234 + 0x4321 with no stalls:
  - sum_nib pulses 5,5,5,5.
  - done in the cycle after the 4th accept, with c_out=0 and overflow=0.
- WORDS=4, 0xFFFF + 0x0001, c_in=0:
  - sum nibbles 0,0,0,0.
  - c_out=1, overflow=0.
- WORDS=4, 0x7FFF + 0x0001:
  - sum nibbles 0,0,0,8.
  - c_out=0, overflow=1.
  - Then 0x8000 + 0x8000: sum 0x0000, c_out=1, overflow=1.
- WORDS=4, 0x1234 + 0x4321 with random in_valid gaps (up to 5 idle cycles):
  - Same sum nibbles as the no-stall case, with no extra sum_valid pulses.
  - done exactly once.
- Assert abort in the same cycle as the 3rd in_valid:
  - No 3rd sum_valid and no done; the block returns to IDLE.
  - Then start 0x0001 + 0x0001: result 0x0002.
  - Separately, assert rst after 2 beats: all outputs read 0 immediately.
- WORDS=1, c_in=1, 0xF + 0x0:
  - sum_nib=0, c_out=1, overflow=0.
  - done in cycle start+2.
  - start re-asserted in the done cycle is honoured.
